booth_mac_accumulator: RTL and testbench
========================================

# booth_mac_accumulator

Accumulation stage placed directly downstream of the radix-4 Booth multiplier inside each systolic-array processing element. It tracks operand tags through the multiplier's fixed pipeline latency, sums the signed 2N-bit products of one dot product into a guarded accumulator with saturation, and presents each finished dot-product result in a valid/ready output register. Results that finish while the output register is still occupied are dropped and reported through a sticky overrun flag.

## Interface
- N, 32, operand width; products arrive as 2N-bit signed values.
- GUARD, 8, accumulator guard bits; ACC_W = 2N+GUARD (72 at defaults).
- MULT_LAT, 2, cycles from operands (and tags) entering the multiplier to the matching product on prod_in; must be ≥1.
- CNT_W, 16, width of the per-result product counter.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low.
- in_valid  in  1  operands entering the multiplier this cycle.
- in_last  in  1  qualifies in_valid; this operand pair ends the current dot product.
- prod_in  in  2N  signed product from the multiplier; sampled only when the delayed in_valid tag is high.
- out_ready  in  1  consumer accepts the result.
- out_valid  out  1  result register holds an unconsumed result.
- acc_out  out  ACC_W  signed dot-product result.
- res_cnt  out  CNT_W  number of products summed into acc_out (saturates at all-ones).
- res_sat  out  1  saturation occurred while producing acc_out.
- overrun  out  1  sticky: at least one result was dropped; cleared only by reset.
- busy  out  1  partial sum open or tags in flight.

## Operation
- Tag pipeline: MULT_LAT-deep shift register of {in_valid, in_last}; stage output is {v_d, l_d}, aligned with prod_in.
- FSM states: IDLE (no open sum) and ACCUM (partial sum held in acc, cnt).
- IDLE, v_d=1: acc ← sext(prod_in), cnt ← 1, sat ← 0; go to ACCUM unless l_d=1.
- ACCUM, v_d=1: acc ← sat_add(acc, sext(prod_in)), cnt ← cnt+1 (saturating); sat |= overflow; on l_d=1 return to IDLE.
- Any state, v_d=0: hold.
- sat_add: compute the (ACC_W+1)-bit sum; if the two top bits differ, clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1) by sign of the true sum and flag overflow.
- Completion (v_d=1 and l_d=1): the final value (including this product) is the result. If out_valid=0, or out_valid=1 with out_ready=1 in the same cycle, load acc_out/res_cnt/res_sat and set out_valid. Otherwise drop the result, set overrun, and leave the held result unchanged.
- out_valid clears on out_valid&&out_ready when no new result loads in that cycle.
- A single-product dot product (in_valid&&in_last from IDLE) yields acc_out = sext(product), res_cnt = 1.
- busy = (state==ACCUM) | OR of the tag-pipeline valid bits.
- in_last with in_valid=0 is ignored.

## Timing
- Reset (rst=0 at a clock edge): out_valid=0, acc_out=0, res_cnt=0, res_sat=0, overrun=0, busy=0, FSM=IDLE, all tag bits=0. Reset mid-sum discards the partial sum and all in-flight tags. Products that arrive after reset release, from operands issued before reset, are ignored.
- Operands issued at cycle t: product is accumulated at the edge ending cycle t+MULT_LAT.
- Result latency: in_valid&&in_last at cycle t → out_valid=1 from cycle t+MULT_LAT+1.
- Throughput: one product per cycle. Back-to-back dot products are supported with no gap: the first product of the next sum can arrive in the cycle after a last.
- Output handshake: acc_out, res_cnt and res_sat are stable while out_valid=1 and out_ready=0.

## Test plan
- MULT_LAT=2. Issue products 3, -5, 7 on consecutive cycles with in_last on the third → out_valid at t+3, acc_out=5, res_cnt=3, res_sat=0.
- Single element: product (-2^31)·(-2^31)=2^62 with last → acc_out=2^62 sign-extended to 72 bits, res_cnt=1.
- Saturation: GUARD=1, N=4. Accumulate six products of +49 → acc_out clamps to +255, res_sat=1. The next dot product [1] → acc_out=1, res_sat=0.
- Backpressure: hold out_ready=0. Complete result A=10, then result B=20 → acc_out stays 10 and overrun=1. Raise out_ready in the same cycle a third result C=30 completes → acc_out=30, and out_valid stays 1.
- Reset mid-sum: two products issued, then rst=0 for one cycle while tags are in flight → all outputs 0 and busy=0. The next sum [4] gives acc_out=4, res_cnt=1.
- Gapped input: products 1, (gap of 2 idle cycles), 2, last 3 → acc_out=6, res_cnt=3, and out_valid rises exactly MULT_LAT+1 cycles after the last operand is issued.

Source files
------------

// File: rtl/booth_mac_accumulator.sv
// Dot-product accumulator behind the Booth multiplier: tags ride alongside the multiplier latency,
// products sum into a guarded saturating accumulator, finished results sit in a valid/ready register.
module booth_mac_accumulator #(
  parameter int N        = 32,
  parameter int GUARD    = 8,
  parameter int MULT_LAT = 2,
  parameter int CNT_W    = 16,
  localparam int ACC_W   = 2*N + GUARD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic [2*N-1:0]          prod_in,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0]        res_cnt,
  output logic                    res_sat,
  output logic                    overrun,
  output logic                    busy
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                  state;
  logic [MULT_LAT-1:0]     tag_v;
  logic [MULT_LAT-1:0]     tag_l;
  logic                    v_d;
  logic                    l_d;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic                    sat;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W:0]   sum_wide;
  logic                    ovf;
  logic signed [ACC_W-1:0] sum_sat;
  logic signed [ACC_W-1:0] next_acc;
  logic [CNT_W-1:0]        next_cnt;
  logic                    next_sat;
  logic                    done;
  logic                    load;

  assign v_d = tag_v[MULT_LAT-1];
  assign l_d = tag_l[MULT_LAT-1];

  assign prod_ext = {{GUARD{prod_in[2*N-1]}}, prod_in};
  assign sum_wide = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
  // The extra top bit holds the true sign; disagreement with the next bit means the sum left ACC_W range.
  assign ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

  always_comb begin
    sum_sat = sum_wide[ACC_W-1:0];
    if (ovf) begin
      sum_sat = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_comb begin
    next_acc = prod_ext;
    next_cnt = CNT_W'(1);
    next_sat = 1'b0;
    if (state == ACCUM) begin
      next_acc = sum_sat;
      next_cnt = (&cnt) ? cnt : cnt + CNT_W'(1);
      next_sat = sat | ovf;
    end
  end

  assign done = v_d & l_d;
  // A finishing result may replace the held one only if that one is absent or leaving this cycle.
  assign load = done & (~out_valid | out_ready);
  assign busy = (state == ACCUM) | (|tag_v);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      tag_v     <= '0;
      tag_l     <= '0;
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      acc_out   <= '0;
      res_cnt   <= '0;
      res_sat   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      tag_v[0] <= in_valid;
      tag_l[0] <= in_valid & in_last;
      for (int i = 1; i < MULT_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_l[i] <= tag_l[i-1];
      end

      if (v_d) begin
        acc   <= next_acc;
        cnt   <= next_cnt;
        sat   <= next_sat;
        state <= l_d ? IDLE : ACCUM;
      end

      if (load) begin
        out_valid <= 1'b1;
        acc_out   <= next_acc;
        res_cnt   <= next_cnt;
        res_sat   <= next_sat;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (done && !load) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Directed bench: timestamped-queue reference model compared every cycle, plus literal expectations.
module tb_booth_mac_accumulator;
  localparam int N = 32, GUARD = 8, ML = 2, CNT_W = 16, ACC_W = 2*N + GUARD;
  localparam logic signed [127:0] AMAX = (128'sd1 <<< (ACC_W-1)) - 128'sd1;
  localparam logic signed [127:0] AMIN = -(128'sd1 <<< (ACC_W-1));

  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [2*N-1:0] prod_in = '0;
  logic out_valid, res_sat, overrun, busy;
  logic signed [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] res_cnt;
  logic s_out_valid, s_res_sat, s_overrun, s_busy;
  logic signed [8:0] s_acc_out;
  logic [15:0] s_res_cnt;

  always #5 clk = ~clk;

  booth_mac_accumulator #(.N(N), .GUARD(GUARD), .MULT_LAT(ML), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .prod_in(prod_in),
    .out_ready(out_ready), .out_valid(out_valid), .acc_out(acc_out), .res_cnt(res_cnt),
    .res_sat(res_sat), .overrun(overrun), .busy(busy));

  // Narrow instance (ACC_W = 9) to reach the saturation boundary with small products.
  booth_mac_accumulator #(.N(4), .GUARD(1), .MULT_LAT(ML), .CNT_W(16)) sdut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .prod_in(prod_in[7:0]),
    .out_ready(out_ready), .out_valid(s_out_valid), .acc_out(s_acc_out), .res_cnt(s_res_cnt),
    .res_sat(s_res_sat), .overrun(s_overrun), .busy(s_busy));

  int total = 0, passed = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Multiplier stand-in: the product issued with the operands appears on prod_in ML cycles later.
  logic [63:0] mp [0:ML];
  logic signed [63:0] cur_p = '0;

  task automatic step(input logic v, input logic l, input logic signed [63:0] p);
    @(posedge clk);
    #1;
    in_valid = v;
    in_last  = l;
    cur_p    = p;
    for (int i = ML; i > 0; i--) mp[i] = mp[i-1];
    mp[0]   = v ? p : {$urandom, $urandom};
    prod_in = mp[ML];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 64'sd0);
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!out_valid && n < 20) begin
      step(1'b0, 1'b0, 64'sd0);
      n++;
    end
    chk(nm, out_valid, 1);
  endtask

  // Reference model: each issued operand becomes a timestamped entry, applied when its time comes.
  typedef struct { longint due; bit last; logic signed [63:0] p; } ent_t;
  ent_t mq[$];
  ent_t e;
  longint cyc_n = 0;
  bit m_open = 0, m_sat = 0, m_ov = 0, m_rsat = 0, m_overrun = 0, m_done;
  logic signed [127:0] m_sum = '0, m_acc = '0;
  int m_cnt = 0;
  logic [15:0] m_rcnt = '0;

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      m_open = 0; m_sat = 0; m_ov = 0; m_rsat = 0; m_overrun = 0;
      m_sum = '0; m_acc = '0; m_cnt = 0; m_rcnt = '0;
    end else begin
      m_done = 0;
      if (mq.size() > 0 && mq[0].due == cyc_n) begin
        e = mq.pop_front();
        if (!m_open) begin
          m_sum = e.p; m_cnt = 1; m_sat = 0;
        end else begin
          m_sum = m_sum + e.p;
          if (m_sum > AMAX) begin m_sum = AMAX; m_sat = 1; end
          else if (m_sum < AMIN) begin m_sum = AMIN; m_sat = 1; end
          if (m_cnt < 65535) m_cnt++;
        end
        m_open = !e.last;
        m_done = e.last;
      end
      if (m_done) begin
        if (!m_ov || out_ready) begin
          m_ov = 1; m_acc = m_sum; m_rcnt = 16'(m_cnt); m_rsat = m_sat;
        end else begin
          m_overrun = 1;
        end
      end else if (m_ov && out_ready) begin
        m_ov = 0;
      end
      if (in_valid) mq.push_back('{cyc_n + ML, in_last, cur_p});
    end
    cyc_n++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_out_valid", out_valid, m_ov);
      chk("cyc_acc_out", acc_out, m_acc[ACC_W-1:0]);
      chk("cyc_res_cnt", res_cnt, m_rcnt);
      chk("cyc_res_sat", res_sat, m_rsat);
      chk("cyc_overrun", overrun, m_overrun);
      chk("cyc_busy", busy, m_open || (mq.size() != 0));
    end
  end

  initial begin
    for (int i = 0; i <= ML; i++) mp[i] = '0;
    rst = 1'b0;
    idle(2);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc_out", acc_out, 0);
    chk("rst_res_cnt", res_cnt, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    chk_en = 1'b1;
    rst = 1'b1;

    // 3 + -5 + 7 = 5, visible three cycles after the last operand
    step(1, 0, 64'sd3); step(1, 0, -64'sd5); step(1, 1, 64'sd7);
    step(0, 0, 0); chk("basic_t1", out_valid, 0);
    step(0, 0, 0); chk("basic_t2", out_valid, 0);
    step(0, 0, 0); chk("basic_t3", out_valid, 1);
    chk("basic_acc", acc_out, 72'd5);
    chk("basic_cnt", res_cnt, 3);
    chk("basic_sat", res_sat, 0);
    chk("model_basic", m_acc[ACC_W-1:0], 72'd5);
    idle(2);

    // single product 2^62
    step(1, 1, 64'sh4000_0000_0000_0000);
    idle(3);
    chk("single_valid", out_valid, 1);
    chk("single_acc", acc_out, 72'h00_4000_0000_0000_0000);
    chk("single_cnt", res_cnt, 1);
    idle(2);

    // six products of 49: narrow instance clamps to 255, wide instance holds 294
    for (int i = 0; i < 6; i++) step(1, i == 5, 64'sd49);
    wait_valid("sat_wait");
    chk("sat_s_valid", s_out_valid, 1);
    chk("sat_s_acc", s_acc_out, 9'h0FF);
    chk("sat_s_sat", s_res_sat, 1);
    chk("sat_s_cnt", s_res_cnt, 6);
    chk("sat_wide_acc", acc_out, 72'd294);
    idle(1);
    step(1, 1, 64'sd1);
    wait_valid("sat_next_wait");
    chk("sat_next_acc", s_acc_out, 9'd1);
    chk("sat_next_sat", s_res_sat, 0);
    idle(2);

    // backpressure: B dropped behind A, C loads as A is consumed
    out_ready = 1'b0;
    step(1, 1, 64'sd10); idle(3);
    chk("bp_a", acc_out, 72'd10);
    step(1, 1, 64'sd20); idle(3);
    chk("bp_hold", acc_out, 72'd10);
    chk("bp_overrun", overrun, 1);
    step(1, 1, 64'sd30);
    step(0, 0, 0);
    step(0, 0, 0); out_ready = 1'b1;
    step(0, 0, 0); out_ready = 1'b0;
    chk("bp_c", acc_out, 72'd30);
    chk("bp_c_valid", out_valid, 1);
    out_ready = 1'b1;
    idle(2);

    // reset while a sum is open and a tag is in flight
    step(1, 0, 64'sd100); step(1, 0, 64'sd200); step(0, 0, 0);
    chk("mid_busy", busy, 1);
    rst = 1'b0;
    step(0, 0, 0); rst = 1'b1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_acc", acc_out, 0);
    idle(2);
    chk("mid_stale_busy", busy, 0);
    step(1, 1, 64'sd4);
    wait_valid("mid_next_wait");
    chk("mid_next_acc", acc_out, 72'd4);
    chk("mid_next_cnt", res_cnt, 1);
    idle(2);

    // gapped input with a stray in_last while idle
    step(1, 0, 64'sd1); step(0, 1, 0); step(0, 0, 0);
    step(1, 0, 64'sd2); step(1, 1, 64'sd3);
    step(0, 0, 0); chk("gap_t1", out_valid, 0);
    step(0, 0, 0); chk("gap_t2", out_valid, 0);
    step(0, 0, 0); chk("gap_t3", out_valid, 1);
    chk("gap_acc", acc_out, 72'd6);
    chk("gap_cnt", res_cnt, 3);
    idle(2);

    // back-to-back dot products [5] then [6,7]
    step(1, 1, 64'sd5); step(1, 0, 64'sd6); step(1, 1, 64'sd7);
    wait_valid("b2b_first");
    chk("b2b_first_acc", acc_out, 72'd5);
    idle(1);
    wait_valid("b2b_second");
    chk("b2b_second_acc", acc_out, 72'd13);
    idle(4);
    chk("end_busy", busy, 0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
